// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_if
//  Description : Instruction-memory request/response bundle between the fetch
//                stage and the instruction memory. At most one request is
//                outstanding at a time.
//                  inst_req     - request valid (fetch -> memory)
//                  inst_addr    - request address (fetch -> memory)
//                  inst_addr_ok - request accepted this cycle (memory -> fetch)
//                  inst_data_ok - inst_rdata valid this cycle (memory -> fetch)
//                  inst_rdata   - returned instruction word (memory -> fetch)
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    // Fetch stage side
    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    // Instruction memory side
    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction fetch stage with a single-outstanding-request
//                memory port, a one-word skid buffer and the IF/ID register.
//                Redirects coming from ID take effect after the delay-slot
//                instruction (branch PC + 4) has been delivered.
//  Ports       :
//    clk       in   clock, all state updates on the rising edge
//    reset     in   asynchronous active-low reset
//    pcsource  in   redirect select for the instruction leaving ID
//                   (00 sequential, 01 bpc, 10 jrpc, 11 jpc)
//    bpc/jrpc/jpc in branch, register-jump and jump targets from ID
//    id_stall  in   ID cannot accept a new instruction this cycle
//    mem       if   instruction memory port (master side)
//    o_pc      out  IF/ID register: instruction PC
//    o_inst    out  IF/ID register: instruction word
//    o_valid   out  IF/ID register holds a live instruction
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [1:0]  pcsource,
    input  wire logic [31:0] bpc,
    input  wire logic [31:0] jrpc,
    input  wire logic [31:0] jpc,
    input  wire logic        id_stall,
    if_stage_if.master       mem,
    output logic      [31:0] o_pc,
    output logic      [31:0] o_inst,
    output logic             o_valid
);

    // REQ  : request on the bus, waiting for addr_ok
    // WAIT : request accepted, waiting for data_ok
    // FULL : word parked in the buffer because the IF/ID slot was occupied
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic [31:0] buffer;
    logic [31:0] buffer_next;
    logic        redirect_pending;
    logic        redirect_pending_next;
    logic [31:0] pending_target;
    logic [31:0] pending_target_next;
    logic [31:0] o_pc_next;
    logic [31:0] o_inst_next;
    logic        o_valid_next;

    logic        depart;
    logic        valid_depart;
    logic        redirect_now;
    logic [31:0] redirect_target;
    logic        load;
    logic [31:0] load_word;

    // The slot frees when it is empty or when ID takes its instruction.
    // Only a real instruction leaving ID may carry a redirect, so pcsource
    // is qualified with valid_depart.
    assign depart       = !o_valid || !id_stall;
    assign valid_depart = o_valid && !id_stall;
    assign redirect_now = valid_depart && (pcsource != 2'b00);

    always_comb begin
        redirect_target = jpc;
        case (pcsource)
            2'b01:   redirect_target = bpc;
            2'b10:   redirect_target = jrpc;
            default: redirect_target = jpc;
        endcase
    end

    assign mem.inst_req  = (state == S_REQ);
    assign mem.inst_addr = fetch_pc;

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_next            = state;
        fetch_pc_next         = fetch_pc;
        buffer_next           = buffer;
        redirect_pending_next = redirect_pending;
        pending_target_next   = pending_target;
        o_pc_next             = o_pc;
        o_inst_next           = o_inst;
        o_valid_next          = o_valid;
        load                  = 1'b0;
        load_word             = buffer;

        case (state)
            S_REQ: begin
                if (mem.inst_addr_ok) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // data_ok is only meaningful here; other states ignore it
                if (mem.inst_data_ok) begin
                    if (depart) begin
                        load       = 1'b1;
                        load_word  = mem.inst_rdata;
                        state_next = S_REQ;
                    end else begin
                        buffer_next = mem.inst_rdata;
                        state_next  = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (depart) begin
                    load       = 1'b1;
                    load_word  = buffer;
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase

        if (load) begin
            o_pc_next    = fetch_pc;
            o_inst_next  = load_word;
            o_valid_next = 1'b1;
            // The word loaded now is the delay slot of any branch leaving
            // this cycle (or of one that left earlier and is pending), so
            // the next fetch goes straight to the target.
            if (redirect_now) begin
                fetch_pc_next = redirect_target;
            end else if (redirect_pending) begin
                fetch_pc_next         = pending_target;
                redirect_pending_next = 1'b0;
            end else begin
                fetch_pc_next = fetch_pc + 32'd4;
            end
        end else if (valid_depart) begin
            o_valid_next = 1'b0;
            // Delay slot not fetched yet: remember the target until it loads.
            if (redirect_now) begin
                redirect_pending_next = 1'b1;
                pending_target_next   = redirect_target;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_REQ;
            fetch_pc         <= RESET_PC;
            buffer           <= 32'd0;
            redirect_pending <= 1'b0;
            pending_target   <= 32'd0;
            o_pc             <= 32'd0;
            o_inst           <= 32'd0;
            o_valid          <= 1'b0;
        end else begin
            state            <= state_next;
            fetch_pc         <= fetch_pc_next;
            buffer           <= buffer_next;
            redirect_pending <= redirect_pending_next;
            pending_target   <= pending_target_next;
            o_pc             <= o_pc_next;
            o_inst           <= o_inst_next;
            o_valid          <= o_valid_next;
        end
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, 32'hBFC0_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; clears all state when 0.
REQ-004 pcsource  in  2  ID redirect select for the instruction leaving ID: 00 sequential, 01 bpc, 10 jrpc, 11 jpc.
REQ-005 bpc, jrpc, jpc  in  32 each  ID-computed branch, register-jump and jump targets.
REQ-006 id_stall  in  1  ID cannot accept a new instruction this cycle.
REQ-007 inst_req  out  1  instruction memory request valid.
REQ-008 inst_addr  out  32  request address, equal to fetch PC.
REQ-009 inst_addr_ok  in  1  memory accepted request this cycle.
REQ-010 inst_data_ok  in  1  inst_rdata valid this cycle.
REQ-011 inst_rdata  in  32  returned instruction word.
REQ-012 o_pc, o_inst  out  32 each  IF/ID register contents to ID.
REQ-013 o_valid  out  1  o_pc/o_inst hold a live instruction.

Function
REQ-014 At most one memory request outstanding; no new request until its data_ok.
REQ-015 FSM states: REQ (inst_req=1), WAIT (awaiting data), FULL (word held in internal buffer, IF/ID slot occupied).
REQ-016 REQ -> WAIT when inst_addr_ok=1; otherwise stay REQ, inst_addr stable.
REQ-017 Slot frees this cycle ("depart") when o_valid=0, or o_valid=1 and id_stall=0.
REQ-018 WAIT + inst_data_ok + depart: load o_inst=inst_rdata, o_pc=fetch PC, o_valid=1, advance PC, -> REQ.
REQ-019 WAIT + inst_data_ok + no depart: store word in buffer, -> FULL; PC not advanced.
REQ-020 FULL + depart: load buffer into IF/ID register, advance PC, -> REQ; FULL + no depart: hold.
REQ-021 Departure of a valid instruction with no load same cycle: o_valid -> 0.
REQ-022 PC advance on load: if valid instruction departs same cycle with pcsource!=00, next PC = selected target; else if redirect_pending, next PC = pending target, pending cleared; else next PC = loaded PC + 4.
REQ-023 Valid instruction departs with pcsource!=00 and no load that cycle: latch target, set redirect_pending (applied after delay-slot load).
REQ-024 Effect: delay-slot instruction (branch PC + 4) always delivered, next fetch is target; PC arithmetic modulo 2^32 (0xFFFF_FFFC + 4 = 0).
REQ-025 pcsource ignored while o_valid=0 or id_stall=1.
REQ-026 inst_data_ok outside WAIT is ignored.

Reset
REQ-027 On reset=0: state REQ, fetch PC=RESET_PC, o_pc=0, o_inst=0, o_valid=0, buffer=0, redirect_pending=0; inst_req=1 in first cycle after release.
REQ-028 Reset mid-transaction abandons the outstanding request; memory side is reset by the same signal.

Verification
REQ-029 Release reset, memory addr_ok and data_ok next cycle, id_stall=0 -> inst_addr 0xBFC00000, 0xBFC00004, 0xBFC00008 in order; o_valid=1 per returned word, o_pc matching.
REQ-030 id_stall=1 for 5 cycles with word returned -> FSM FULL, o_inst unchanged, no new inst_req; on id_stall=0 buffered word loads next edge, next request at PC+4.
REQ-031 Branch at 0x100 departs with pcsource=01, bpc=0x200, same cycle as delay slot 0x104 data_ok -> o_pc=0x104, next inst_addr=0x200.
REQ-032 Branch departs with pcsource=11, jpc=0x400, two cycles before 0x104 data -> redirect_pending set; after 0x104 loads, inst_addr=0x400, pending cleared.
REQ-033 inst_addr_ok held 0 for 3 cycles -> inst_req stays 1, inst_addr stable.
REQ-034 Assert reset=0 in WAIT with o_valid=1 -> asynchronously o_valid=0, o_pc=0; after release inst_addr=0xBFC00000.
